// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file control stage.
package rf_ctrl_pkg;

  localparam int unsigned DataW  = 4;
  localparam int unsigned AddrW  = 3;
  localparam int unsigned InstrW = 12;

  // Instruction field positions: {opcode, dst, src1, src2}; LDI reuses the low nibble as imm.
  localparam int unsigned OpMsb   = 11;
  localparam int unsigned OpLsb   = 9;
  localparam int unsigned DstMsb  = 8;
  localparam int unsigned DstLsb  = 6;
  localparam int unsigned Src1Msb = 5;
  localparam int unsigned Src1Lsb = 3;
  localparam int unsigned Src2Msb = 2;
  localparam int unsigned Src2Lsb = 0;
  localparam int unsigned ImmMsb  = 3;
  localparam int unsigned ImmLsb  = 0;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpAnd  = 3'b010,
    OpOr   = 3'b011,
    OpXor  = 3'b100,
    OpLdi  = 3'b101,
    OpNop  = 3'b110,
    OpHalt = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StRead = 3'd1,
    StExec = 3'd2,
    StWb   = 3'd3,
    StHalt = 3'd4
  } state_e;

  // Opcodes that read two registers and go through the ALU.
  function automatic logic is_alu_op(opcode_e op);
    return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpOr) || (op == OpXor);
  endfunction

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU: ADD/SUB report carry/borrow, logic ops clear carry.
module alu4
  import rf_ctrl_pkg::*;
(
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  opcode_e          op,
  output logic [DataW-1:0] result,
  output logic             carry
);

  logic [DataW:0] w_wide;

  // One extra bit holds carry for ADD and borrow for SUB (a < b wraps into the top bit).
  always_comb begin
    w_wide = '0;
    case (op)
      OpAdd:   w_wide = {1'b0, a} + {1'b0, b};
      OpSub:   w_wide = {1'b0, a} - {1'b0, b};
      OpAnd:   w_wide = {1'b0, a & b};
      OpOr:    w_wide = {1'b0, a | b};
      OpXor:   w_wide = {1'b0, a ^ b};
      default: w_wide = '0;
    endcase
  end

  assign result = w_wide[DataW-1:0];
  assign carry  = w_wide[DataW];

endmodule

// File: rtl/rf_controller.sv
// Multi-cycle control stage sequencing reads, ALU execution and writeback for an 8x4 register file.
module rf_controller
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DataW,
  parameter int unsigned ADDR_W = AddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [11:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] RF_ad1,
  output logic [ADDR_W-1:0] RF_ad2,
  output logic [ADDR_W-1:0] RF_wad,
  output logic              RF_we,
  output logic [DATA_W-1:0] RF_wd,
  input  logic [DATA_W-1:0] RF_d1,
  input  logic [DATA_W-1:0] RF_d2,
  output logic              done,
  output logic              halted,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [7:0]        instr_count
);

  state_e            r_state;
  state_e            w_state_next;
  opcode_e           r_op;
  logic [ADDR_W-1:0] r_ad1;
  logic [ADDR_W-1:0] r_ad2;
  logic [ADDR_W-1:0] r_wad;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_carry;
  logic [7:0]        r_count;

  opcode_e           w_in_op;
  logic              w_accept;
  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;

  assign w_in_op  = opcode_e'(instr[OpMsb:OpLsb]);
  assign w_accept = instr_valid && (r_state == StIdle);

  alu4 u_alu4 (
    .a      (RF_d1),
    .b      (RF_d2),
    .op     (r_op),
    .result (w_alu_result),
    .carry  (w_alu_carry)
  );

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state decode; HALT is terminal until reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (instr_valid) begin
          if (is_alu_op(w_in_op))    w_state_next = StRead;
          else if (w_in_op == OpHalt) w_state_next = StHalt;
          else                        w_state_next = StWb;
        end
      end
      StRead:  w_state_next = StExec;
      StExec:  w_state_next = StWb;
      StWb:    w_state_next = StIdle;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StIdle;
    endcase
  end

  // Moore outputs decoded from registered state only, so reset drops RF_we asynchronously.
  always_comb begin
    instr_ready = (r_state == StIdle);
    done        = (r_state == StWb);
    halted      = (r_state == StHalt);
    RF_we       = (r_state == StWb) && (r_op != OpNop);
  end

  // Instruction capture at accept, plus result/flag registration at the end of EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= OpNop;
      r_ad1    <= '0;
      r_ad2    <= '0;
      r_wad    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      if (w_accept && (w_in_op != OpHalt)) begin
        r_op  <= w_in_op;
        r_wad <= instr[DstMsb:DstLsb];
        if (is_alu_op(w_in_op)) begin
          r_ad1 <= instr[Src1Msb:Src1Lsb];
          r_ad2 <= instr[Src2Msb:Src2Lsb];
        end
        // LDI bypasses the ALU; its immediate is the writeback value.
        if (w_in_op == OpLdi) r_result <= instr[ImmMsb:ImmLsb];
      end
      if (r_state == StExec) begin
        r_result <= w_alu_result;
        r_zero   <= (w_alu_result == '0);
        r_carry  <= w_alu_carry;
      end
    end
  end

  // Retired-instruction counter; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_count <= '0;
    else if (r_state == StWb)  r_count <= r_count + 8'd1;
  end

  assign RF_ad1      = r_ad1;
  assign RF_ad2      = r_ad2;
  assign RF_wad      = r_wad;
  assign RF_wd       = r_result;
  assign zero_flag   = r_zero;
  assign carry_flag  = r_carry;
  assign instr_count = r_count;

endmodule

// File: tb/tb_rf_controller.sv
// Scoreboard bench for rf_controller with a behavioural registered-read register file.
module tb_rf_controller;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [11:0] instr;
  logic       instr_ready;
  logic [2:0] RF_ad1, RF_ad2, RF_wad;
  logic       RF_we;
  logic [3:0] RF_wd;
  logic [3:0] RF_d1, RF_d2;
  logic       done, halted, zero_flag, carry_flag;
  logic [7:0] instr_count;

  rf_controller dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .RF_ad1      (RF_ad1),
    .RF_ad2      (RF_ad2),
    .RF_wad      (RF_wad),
    .RF_we       (RF_we),
    .RF_wd       (RF_wd),
    .RF_d1       (RF_d1),
    .RF_d2       (RF_d2),
    .done        (done),
    .halted      (halted),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: R1=1, R2=2, R3=3 preloaded; reads registered, not reset.
  logic [3:0] rf [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
  always @(posedge clk) begin
    if (RF_we) rf[RF_wad] <= RF_wd;
    RF_d1 <= rf[RF_ad1];
    RF_d2 <= rf[RF_ad2];
  end

  typedef struct {
    logic       we;
    logic [2:0] wad;
    logic [3:0] wd;
    logic       z;
    logic       c;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("RF_we", int'(RF_we), int'(mon_e.we));
        if (mon_e.we) begin
          chk("RF_wad", int'(RF_wad), int'(mon_e.wad));
          chk("RF_wd", int'(RF_wd), int'(mon_e.wd));
        end
        chk("zero_flag", int'(zero_flag), int'(mon_e.z));
        chk("carry_flag", int'(carry_flag), int'(mon_e.c));
        chk("instr_count", int'(instr_count), int'(mon_e.cnt));
        chk("wb_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Present an instruction and wait (bounded) for the accept edge.
  task automatic accept(input logic [11:0] ins, output int c0, output bit ok);
    ok = 1'b0;
    c0 = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (instr_ready) begin
        @(posedge clk);
        #1;
        c0 = cyc;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic issue(input logic [11:0] ins, input logic [3:0] wd, input logic z,
                       input logic c, output int c0);
    bit ok;
    exp_t e;
    logic [2:0] op;
    op = ins[11:9];
    accept(ins, c0, ok);
    if (ok) begin
      e.we  = (op != 3'b110);
      e.wad = ins[8:6];
      e.wd  = wd;
      e.z   = z;
      e.c   = c;
      e.cnt = exp_count;
      e.cyc = c0 + ((op >= 3'b101) ? 0 : 2);
      sb.push_back(e);
      exp_count = exp_count + 8'd1;
    end
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      if (sb.size() == 0 && instr_ready) idle = 1'b1;
      else @(negedge clk);
    end
    if (!idle) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, int'(instr_ready), 1);
    chk({tag, "_ad1"}, int'(RF_ad1), 0);
    chk({tag, "_ad2"}, int'(RF_ad2), 0);
    chk({tag, "_wad"}, int'(RF_wad), 0);
    chk({tag, "_we"}, int'(RF_we), 0);
    chk({tag, "_wd"}, int'(RF_wd), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_halted"}, int'(halted), 0);
    chk({tag, "_zero"}, int'(zero_flag), 0);
    chk({tag, "_carry"}, int'(carry_flag), 0);
    chk({tag, "_count"}, int'(instr_count), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int  c0, last_c0;
  bit  ok;

  initial begin
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 12'h000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("por");

    // ADD R5,R1,R2 -> 3
    issue(12'h14A, 4'h3, 1'b0, 1'b0, c0); drain();
    chk("count_after_add", int'(instr_count), 1);
    // LDI R6,#15 (flags held)
    issue(12'hB8F, 4'hF, 1'b0, 1'b0, c0); drain();
    // ADD R7,R6,R1 -> 15+1 wraps to 0, carry
    issue(12'h1F1, 4'h0, 1'b1, 1'b1, c0); drain();
    // SUB R4,R1,R2 -> 1-2 = F, borrow
    issue(12'h30A, 4'hF, 1'b0, 1'b1, c0); drain();
    // XOR R4,R3,R3 -> 0
    issue(12'h91B, 4'h0, 1'b1, 1'b0, c0); drain();
    // LDI R5,#9 must leave zero=1/carry=0 from XOR
    issue(12'hB49, 4'h9, 1'b1, 1'b0, c0); drain();
    // AND R0,R3,R2 -> 2 ; OR R0,R1,R2 -> 3
    issue(12'h41A, 4'h2, 1'b0, 1'b0, c0); drain();
    issue(12'h60A, 4'h3, 1'b0, 1'b0, c0); drain();
    // ADD R3,R3,R3 uses the old R3 -> 6
    issue(12'h0DB, 4'h6, 1'b0, 1'b0, c0); drain();
    chk("rf_R6", int'(rf[6]), 15);
    chk("rf_R7", int'(rf[7]), 0);
    chk("rf_R4", int'(rf[4]), 0);
    chk("rf_R3", int'(rf[3]), 6);
    chk("rf_R5", int'(rf[5]), 9);

    // Reset during EXEC of ADD R5,R1,R2: no write, R5 keeps 9
    accept(12'h14A, c0, ok);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("rst_exec_we", int'(RF_we), 0);
    chk("rst_exec_ready", int'(instr_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_count = 8'd0;
    @(negedge clk);
    check_reset_vals("mid");
    chk("rst_R5_kept", int'(rf[5]), 9);

    // Back-to-back NOPs with valid held: accept every 2 cycles, count wraps after 256
    last_c0 = 0;
    for (int i = 0; i < 256; i++) begin
      issue(12'hC00, 4'h0, 1'b0, 1'b0, c0);
      if (i > 0) chk("nop_spacing", c0 - last_c0, 2);
      last_c0 = c0;
    end
    drain();
    chk("count_wrap", int'(instr_count), 0);

    // HALT, then hold an ADD request: nothing may happen
    accept(12'hE00, c0, ok);
    @(negedge clk);
    instr = 12'h14A;
    for (int i = 0; i < 20; i++) begin
      chk("halt_halted", int'(halted), 1);
      chk("halt_ready", int'(instr_ready), 0);
      chk("halt_we", int'(RF_we), 0);
      @(negedge clk);
    end
    chk("halt_not_counted", int'(instr_count), 0);
    reset = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_halt_halted", int'(halted), 0);
    chk("post_halt_ready", int'(instr_ready), 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
